// File: rtl/ml_ahb_pkg.sv
// ----------------------------------------------------------------------------
// ml_ahb_pkg
// Shared definitions for the multi-layer AHB slave-port arbiter:
//   - HTRANS encodings
//   - arbiter state encoding (IDLE / OWN / HOLD)
//   - helper that tells whether an owner's current transfer type lets the
//     address phase be handed over at the end of this cycle
// ----------------------------------------------------------------------------
package ml_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,  // no owner
        ST_OWN  = 2'b01,  // owner present, may be re-arbitrated
        ST_HOLD = 2'b10   // owner mid-burst or locked
    } arb_state_t;

    // IDLE and NONSEQ mark a burst boundary; BUSY and SEQ are inside a burst.
    function automatic logic trans_allows_rearb(input logic [1:0] ht);
        return (ht == HTRANS_IDLE) || (ht == HTRANS_NONSEQ);
    endfunction

endpackage

// File: rtl/ml_ahb_prio_sel_n.sv
// ----------------------------------------------------------------------------
// ml_ahb_prio_sel_n
// Combinational N-way lowest-value selector.
// Among requesting masters, aged masters beat non-aged ones; within a class
// the lowest priority value wins and ties resolve to the lowest index.
//   i_req    [NUM_MST-1:0]        request per master
//   i_aged   [NUM_MST-1:0]        starvation flag per master
//   i_prio   [NUM_MST*PRIO_W-1:0] priority of master i at [i*PRIO_W +: PRIO_W]
//   o_winner [NUM_MST-1:0]        one-hot winner (all zero when nobody requests)
//   o_idx    [SEL_W-1:0]          winner index (0 when nobody requests)
//   o_valid                       a winner exists
// ----------------------------------------------------------------------------
module ml_ahb_prio_sel_n #(
    parameter int NUM_MST = 2,
    parameter int PRIO_W  = 3,
    parameter int SEL_W   = 3
) (
    input  logic [NUM_MST-1:0]        i_req,
    input  logic [NUM_MST-1:0]        i_aged,
    input  logic [NUM_MST*PRIO_W-1:0] i_prio,
    output logic [NUM_MST-1:0]        o_winner,
    output logic [SEL_W-1:0]          o_idx,
    output logic                      o_valid
);

    logic              w_found;
    logic              w_best_aged;
    logic [PRIO_W-1:0] w_best_prio;
    logic [SEL_W-1:0]  w_best_idx;
    logic              w_take;

    // Ascending scan with a strict comparison keeps the lowest index on ties.
    always_comb begin
        w_found     = 1'b0;
        w_best_aged = 1'b0;
        w_best_prio = '0;
        w_best_idx  = '0;
        w_take      = 1'b0;
        for (int i = 0; i < NUM_MST; i++) begin
            w_take = 1'b0;
            if (i_req[i]) begin
                w_take = !w_found
                      || (i_aged[i] && !w_best_aged)
                      || ((i_aged[i] == w_best_aged)
                          && (i_prio[i*PRIO_W +: PRIO_W] < w_best_prio));
            end
            if (w_take) begin
                w_found     = 1'b1;
                w_best_aged = i_aged[i];
                w_best_prio = i_prio[i*PRIO_W +: PRIO_W];
                w_best_idx  = SEL_W'(i);
            end
        end
    end

    always_comb begin
        o_winner = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            o_winner[i] = w_found && (w_best_idx == SEL_W'(i));
        end
    end

    assign o_idx   = w_best_idx;
    assign o_valid = w_found;

endmodule

// File: rtl/ml_ahb_port_arbiter.sv
// ----------------------------------------------------------------------------
// ml_ahb_port_arbiter
// Arbiter for one multi-layer AHB slave port shared by NUM_MST masters.
// Picks the address-phase owner by priority (lower value wins, tie -> lower
// index), holds ownership across bursts and locked sequences, promotes
// starving requesters after AGE_MAX lost arbitrations, and tracks the
// data-phase owner for the data mux.
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   req        [NUM_MST]     per-master address-phase request
//   prio       [NUM_MST*PRIO_W] per-master priority
//   htrans     [NUM_MST*2]   per-master HTRANS
//   hmastlock  [NUM_MST]     per-master lock
//   hready                   slave-side HREADY
//   grant      [NUM_MST]     one-hot address-phase owner
//   addr_sel   [SEL_W]       owner index for the address mux
//   addr_valid               an owner exists
//   data_sel   [SEL_W]       data-phase master index for the data mux
//   data_valid               data phase active (NONSEQ/SEQ accepted)
// ----------------------------------------------------------------------------
module ml_ahb_port_arbiter
    import ml_ahb_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int PRIO_W  = 3,
    parameter int AGE_MAX = 15,
    parameter int SEL_W   = 3
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [NUM_MST-1:0]        req,
    input  logic [NUM_MST*PRIO_W-1:0] prio,
    input  logic [NUM_MST*2-1:0]      htrans,
    input  logic [NUM_MST-1:0]        hmastlock,
    input  logic                      hready,
    output logic [NUM_MST-1:0]        grant,
    output logic [SEL_W-1:0]          addr_sel,
    output logic                      addr_valid,
    output logic [SEL_W-1:0]          data_sel,
    output logic                      data_valid
);

    localparam int AGE_W = (AGE_MAX < 2) ? 1 : $clog2(AGE_MAX + 1);

    arb_state_t         r_state;
    logic [NUM_MST-1:0] r_grant;
    logic [SEL_W-1:0]   r_addr_sel;
    logic               r_addr_valid;
    logic [SEL_W-1:0]   r_data_sel;
    logic               r_data_valid;
    logic [AGE_W-1:0]   r_age [NUM_MST];

    logic [1:0]         w_own_htrans;
    logic               w_own_lock;
    logic [NUM_MST-1:0] w_aged;
    logic               w_ae;
    logic [NUM_MST-1:0] w_win;
    logic [SEL_W-1:0]   w_win_idx;
    logic               w_win_valid;

    // Current owner's transfer type and lock; with no owner the mux reads
    // master 0, which is harmless because IDLE always arbitrates.
    always_comb begin
        w_own_htrans = HTRANS_IDLE;
        w_own_lock   = 1'b0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (r_addr_sel == SEL_W'(i)) begin
                w_own_htrans = htrans[2*i +: 2];
                w_own_lock   = hmastlock[i];
            end
        end
    end

    // A master is promoted once it has lost AGE_MAX arbitrations in a row.
    always_comb begin
        w_aged = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            w_aged[i] = (AGE_MAX != 0) && (r_age[i] == AGE_W'(AGE_MAX));
        end
    end

    // Arbitration event: port idle, or the owner reached a burst boundary
    // with the slave ready and no lock asserted.
    assign w_ae = (r_state == ST_IDLE)
               || (hready && trans_allows_rearb(w_own_htrans) && !w_own_lock);

    ml_ahb_prio_sel_n #(
        .NUM_MST (NUM_MST),
        .PRIO_W  (PRIO_W),
        .SEL_W   (SEL_W)
    ) u_sel (
        .i_req    (req),
        .i_aged   (w_aged),
        .i_prio   (prio),
        .o_winner (w_win),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_addr_sel   <= '0;
            r_addr_valid <= 1'b0;
            r_data_sel   <= '0;
            r_data_valid <= 1'b0;
            for (int i = 0; i < NUM_MST; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            // Address phase accepted on hready: it becomes the data phase.
            if (hready) begin
                r_data_sel   <= r_addr_sel;
                r_data_valid <= r_addr_valid & w_own_htrans[1];
            end

            if (w_ae) begin
                if (w_win_valid) begin
                    r_grant      <= w_win;
                    r_addr_sel   <= w_win_idx;
                    r_addr_valid <= 1'b1;
                    r_state      <= ST_OWN;
                end else begin
                    r_grant      <= '0;
                    r_addr_sel   <= '0;
                    r_addr_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                // Ages move only at arbitration events: losers that still
                // request count up (saturating), everyone else restarts.
                for (int i = 0; i < NUM_MST; i++) begin
                    if (AGE_MAX == 0) begin
                        r_age[i] <= '0;
                    end else if (req[i] && !w_win[i]) begin
                        if (r_age[i] != AGE_W'(AGE_MAX)) begin
                            r_age[i] <= r_age[i] + AGE_W'(1);
                        end
                    end else begin
                        r_age[i] <= '0;
                    end
                end
            end else if (hready) begin
                // Ready without an event means BUSY/SEQ or a lock is active.
                r_state <= ST_HOLD;
            end
        end
    end

    assign grant      = r_grant;
    assign addr_sel   = r_addr_sel;
    assign addr_valid = r_addr_valid;
    assign data_sel   = r_data_sel;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_ml_ahb_port_arbiter.sv
module tb_ml_ahb_port_arbiter;

    localparam int NM      = 2;
    localparam int PW      = 3;
    localparam int AGE_MAX = 2;
    localparam int SW      = 3;

    logic              HCLK;
    logic              HRESETn;
    logic [NM-1:0]     req;
    logic [NM*PW-1:0]  prio;
    logic [NM*2-1:0]   htrans;
    logic [NM-1:0]     hmastlock;
    logic              hready;
    logic [NM-1:0]     grant;
    logic [SW-1:0]     addr_sel;
    logic              addr_valid;
    logic [SW-1:0]     data_sel;
    logic              data_valid;

    int errors = 0;
    int checks = 0;

    // Reference model state: owner index (-1 = nobody), ages, data phase.
    int m_owner;
    int m_age [NM];
    int m_dsel;
    int m_dval;

    ml_ahb_port_arbiter #(
        .NUM_MST (NM),
        .PRIO_W  (PW),
        .AGE_MAX (AGE_MAX),
        .SEL_W   (SW)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .req        (req),
        .prio       (prio),
        .htrans     (htrans),
        .hmastlock  (hmastlock),
        .hready     (hready),
        .grant      (grant),
        .addr_sel   (addr_sel),
        .addr_valid (addr_valid),
        .data_sel   (data_sel),
        .data_valid (data_valid)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic r, input int p, input logic [1:0] ht, input logic lk);
        req[i]          = r;
        prio[i*PW +: PW] = PW'(p);
        htrans[2*i +: 2] = ht;
        hmastlock[i]    = lk;
    endtask

    task automatic clear_inputs();
        req = '0; prio = '0; htrans = '0; hmastlock = '0; hready = 1'b1;
    endtask

    function automatic void m_reset();
        m_owner = -1;
        for (int i = 0; i < NM; i++) m_age[i] = 0;
        m_dsel = 0;
        m_dval = 0;
    endfunction

    function automatic int m_prio(input int i);
        return int'(prio[i*PW +: PW]);
    endfunction

    function automatic bit m_is_aged(input int i);
        return (AGE_MAX > 0) && (m_age[i] == AGE_MAX);
    endfunction

    // Winner: restrict to starving requesters if any exist, then take the
    // smallest priority value, first index on ties.
    function automatic int m_pick();
        bit any_aged = 0;
        int best = -1;
        for (int i = 0; i < NM; i++)
            if (req[i] && m_is_aged(i)) any_aged = 1;
        for (int i = 0; i < NM; i++) begin
            if (req[i] && (!any_aged || m_is_aged(i))) begin
                if (best < 0 || m_prio(i) < m_prio(best)) best = i;
            end
        end
        return best;
    endfunction

    // Advance the model by one clock using the inputs currently applied,
    // clock the DUT, then compare every output.
    task automatic step();
        int ht;
        int lk;
        int win;
        bit ae;
        if (!HRESETn) begin
            m_reset();
        end else begin
            ht = (m_owner < 0) ? 0 : int'(htrans[2*m_owner +: 2]);
            lk = (m_owner < 0) ? 0 : int'(hmastlock[m_owner]);
            ae = (m_owner < 0) || (hready && (ht == 0 || ht == 2) && lk == 0);
            if (hready) begin
                m_dsel = (m_owner < 0) ? 0 : m_owner;
                m_dval = (m_owner >= 0 && ht >= 2) ? 1 : 0;
            end
            if (ae) begin
                win = m_pick();
                for (int i = 0; i < NM; i++) begin
                    if (req[i] && i != win) m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
                    else m_age[i] = 0;
                end
                m_owner = win;
            end
        end
        @(posedge HCLK);
        #1;
        chk("grant",      32'(grant),      (m_owner < 0) ? 0 : (1 << m_owner));
        chk("addr_sel",   32'(addr_sel),   (m_owner < 0) ? 0 : m_owner);
        chk("addr_valid", 32'(addr_valid), (m_owner < 0) ? 0 : 1);
        chk("data_sel",   32'(data_sel),   m_dsel);
        chk("data_valid", 32'(data_valid), m_dval);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},  32'(grant),      0);
        chk({tag, "_asel"},   32'(addr_sel),   0);
        chk({tag, "_avalid"}, 32'(addr_valid), 0);
        chk({tag, "_dsel"},   32'(data_sel),   0);
        chk({tag, "_dvalid"}, 32'(data_valid), 0);
    endtask

    initial begin
        HRESETn = 1'b1;
        clear_inputs();
        m_reset();

        // 1. reset and idle
        #1 HRESETn = 1'b0;
        #1 chk_all_zero("rst_async");
        step();
        step();
        #2 HRESETn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_grant", 32'(grant), 0);
            chk("idle_dvalid", 32'(data_valid), 0);
        end

        // 2. priority, then tie to lower index
        set_m(0, 1, 3, 2'b10, 0);
        set_m(1, 1, 1, 2'b10, 0);
        step();
        chk("prio_grant", 32'(grant), 32'b10);
        set_m(0, 1, 2, 2'b10, 0);
        set_m(1, 1, 2, 2'b10, 0);
        step();
        chk("tie_grant", 32'(grant), 32'b01);
        clear_inputs();
        step();
        step();

        // 3. burst hold: M1 with better priority waits for the burst to end
        set_m(0, 1, 3, 2'b10, 0);
        step();
        chk("burst_own", 32'(grant), 32'b01);
        step();
        chk("burst_nseq_dvalid", 32'(data_valid), 1);
        set_m(0, 1, 3, 2'b11, 0);
        set_m(1, 1, 0, 2'b10, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("burst_hold", 32'(grant), 32'b01);
        end
        set_m(0, 0, 3, 2'b00, 0);
        step();
        chk("burst_handover", 32'(grant), 32'b10);
        clear_inputs();
        step();
        step();

        // 4. locked owner with wait states
        set_m(0, 1, 7, 2'b10, 1);
        step();
        chk("lock_own", 32'(grant), 32'b01);
        set_m(1, 1, 0, 2'b10, 0);
        for (int k = 0; k < 6; k++) begin
            hready = k[0];
            htrans[1:0] = k[0] ? 2'b11 : 2'b10;
            step();
            chk("lock_hold", 32'(grant), 32'b01);
        end
        hready = 1'b1;
        set_m(0, 1, 7, 2'b00, 0);
        step();
        chk("lock_release", 32'(grant), 32'b10);
        clear_inputs();
        step();
        step();

        // 5. aging: low-priority M1 wins the third event
        set_m(0, 1, 0, 2'b10, 0);
        set_m(1, 1, 7, 2'b10, 0);
        step();
        chk("age_ae1", 32'(grant), 32'b01);
        step();
        chk("age_ae2", 32'(grant), 32'b01);
        step();
        chk("age_ae3", 32'(grant), 32'b10);
        step();
        chk("age_ae4", 32'(grant), 32'b01);
        clear_inputs();
        step();
        step();

        // 6. reset in the middle of a burst
        set_m(0, 1, 0, 2'b10, 0);
        step();
        set_m(0, 1, 0, 2'b11, 0);
        step();
        chk("mid_hold", 32'(grant), 32'b01);
        #2 HRESETn = 1'b0;
        #1 chk_all_zero("mid_rst");
        m_reset();
        step();
        #2 HRESETn = 1'b1;
        set_m(0, 0, 0, 2'b00, 0);
        set_m(1, 1, 3, 2'b10, 0);
        step();
        chk("post_rst_grant", 32'(grant), 32'b10);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NM; i++) begin
                set_m(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            end
            hready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
